// File: rtl/game_sprite_update_sequencer_pkg.sv
// Shared types and constants for the sprite update sequencer.
package game_sprite_update_sequencer_pkg;

  localparam int unsigned N_SPRITES_DEFAULT = 2;
  localparam int unsigned OVR_CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/game_lowest_bit_picker.sv
// Combinational priority picker: reports whether any bit is set and the lowest set index.
module game_lowest_bit_picker #(
  parameter int unsigned N_SPRITES = 2,
  parameter int unsigned ID_W      = 1
) (
  input  logic [N_SPRITES-1:0] req,
  output logic                 any,
  output logic [ID_W-1:0]      idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < int'(N_SPRITES); i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/game_sprite_update_sequencer.sv
// Per-frame scheduler sharing one sprite position-update engine across all enabled sprites.
module game_sprite_update_sequencer
  import game_sprite_update_sequencer_pkg::*;
#(
  parameter int unsigned N_SPRITES = N_SPRITES_DEFAULT,
  parameter int unsigned ID_W      = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic [N_SPRITES-1:0] enable_update,
  input  logic [N_SPRITES-1:0] write_xy,
  output logic                 upd_valid,
  output logic [ID_W-1:0]      upd_id,
  input  logic                 upd_ready,
  input  logic                 upd_done,
  output logic                 busy,
  output logic                 pass_done,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_count
);

  seq_state_t           state_q, state_d;
  logic [N_SPRITES-1:0] pending_q, pending_d;
  logic                 pick_any;
  logic [ID_W-1:0]      pick_idx;
  logic                 valid_d, pass_done_d, overrun_d;
  logic [ID_W-1:0]      id_d;
  logic [OVR_CNT_W-1:0] count_d;

  // Picker looks at the next pending mask so request outputs can be registered.
  game_lowest_bit_picker #(
    .N_SPRITES (N_SPRITES),
    .ID_W      (ID_W)
  ) u_picker (
    .req (pending_d),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    count_d   = overrun_count;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          pending_d = enable_update & ~write_xy;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pending_q == '0) begin
          state_d = ST_IDLE;
        end else if (upd_ready) begin
          pending_d[upd_id] = 1'b0;
          state_d           = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (upd_done) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A frame arriving mid-pass is dropped and only recorded.
    if (frame_start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
      if (overrun_count != {OVR_CNT_W{1'b1}}) count_d = overrun_count + OVR_CNT_W'(1);
    end
    valid_d     = (state_d == ST_ISSUE) && pick_any;
    pass_done_d = (state_d == ST_ISSUE) && !pick_any;
    id_d        = valid_d ? pick_idx : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      upd_valid     <= 1'b0;
      upd_id        <= '0;
      busy          <= 1'b0;
      pass_done     <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      upd_valid     <= valid_d;
      upd_id        <= id_d;
      busy          <= (state_d != ST_IDLE);
      pass_done     <= pass_done_d;
      overrun       <= overrun_d;
      overrun_count <= count_d;
    end
  end

endmodule

// File: tb/tb_game_sprite_update_sequencer.sv
// Randomized directed bench for the sprite update sequencer against a pass-level reference model.
module tb_game_sprite_update_sequencer;

  localparam int unsigned N = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         frame_start;
  logic [N-1:0] enable_update;
  logic [N-1:0] write_xy;
  logic         upd_valid;
  logic [0:0]   upd_id;
  logic         upd_ready;
  logic         upd_done;
  logic         busy;
  logic         pass_done;
  logic         overrun;
  logic [7:0]   overrun_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt = 0;
  bit exp_ovr = 1'b0;
  bit ovr_pend = 1'b0;

  game_sprite_update_sequencer #(.N_SPRITES(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .enable_update (enable_update),
    .write_xy      (write_xy),
    .upd_valid     (upd_valid),
    .upd_id        (upd_id),
    .upd_ready     (upd_ready),
    .upd_done      (upd_done),
    .busy          (busy),
    .pass_done     (pass_done),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the overrun counter at the edge, then check it half a cycle later.
  task automatic tick();
    @(posedge clk);
    exp_ovr = ovr_pend;
    if (ovr_pend && exp_cnt != 255) exp_cnt++;
    ovr_pend = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    upd_done    = 1'b0;
    cyc++;
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("overrun_count", 32'(overrun_count), 32'(exp_cnt));
  endtask

  task automatic ovr_frame();
    frame_start = 1'b1;
    ovr_pend    = 1'b1;
  endtask

  // ovr_mode: 0 none, 1 random frame_start while busy, 2 frame_start every other wait cycle.
  task automatic run_pass(input logic [1:0] en, input logic [1:0] wxy,
                          input int rmin, input int rmax, input int dmin, input int dmax,
                          input int ovr_mode, input bit ovr_at_end);
    int q[$];
    int t0;
    int extra;
    int r;
    int d;
    q = {};
    for (int i = 0; i < int'(N); i++) if (en[i] && !wxy[i]) q.push_back(i);
    extra = 0;
    t0 = cyc;
    enable_update = en;
    write_xy      = wxy;
    frame_start   = 1'b1;
    tick();
    enable_update = 2'($urandom);
    write_xy      = 2'($urandom);
    chk("busy_start", 32'(busy), 32'd1);
    foreach (q[n]) begin
      chk("req_valid", 32'(upd_valid), 32'd1);
      chk("req_id", 32'(upd_id), 32'(q[n]));
      r = $urandom_range(rmax, rmin);
      extra += r;
      for (int j = 0; j < r; j++) begin
        upd_done = 1'($urandom);
        if (ovr_mode == 1 && $urandom_range(3, 0) == 0) ovr_frame();
        tick();
        chk("hold_valid", 32'(upd_valid), 32'd1);
        chk("hold_id", 32'(upd_id), 32'(q[n]));
      end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
      chk("accept_drop", 32'(upd_valid), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      d = $urandom_range(dmax, dmin);
      extra += d;
      for (int j = 0; j < d; j++) begin
        if ((ovr_mode == 1 && $urandom_range(3, 0) == 0) || (ovr_mode == 2 && j % 2 == 0)) ovr_frame();
        tick();
        chk("wait_valid", 32'(upd_valid), 32'd0);
      end
      upd_done = 1'b1;
      tick();
    end
    chk("pass_done", 32'(pass_done), 32'd1);
    chk("pass_len", 32'(cyc - t0), 32'(2 * q.size() + 1 + extra));
    chk("end_valid", 32'(upd_valid), 32'd0);
    if (ovr_at_end) ovr_frame();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pass_done", 32'(pass_done), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    frame_start   = 1'b0;
    enable_update = '0;
    write_xy      = '0;
    upd_ready     = 1'b0;
    upd_done      = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_count", 32'(overrun_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic pass: both sprites, ideal engine.
    run_pass(2'b11, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    // Backpressure on a single sprite.
    run_pass(2'b10, 2'b00, 4, 4, 0, 0, 0, 1'b0);
    // Exclusion by write_xy; inputs scrambled after the snapshot.
    run_pass(2'b11, 2'b01, 0, 1, 0, 1, 0, 1'b0);
    // Empty passes back to back, second frame two cycles after the first.
    run_pass(2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    run_pass(2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    chk("b2b_count", 32'(overrun_count), 32'd0);
    // Randomized passes with stray done pulses and mid-pass frames.
    for (int p = 0; p < 8; p++)
      run_pass(2'($urandom), 2'($urandom), 0, 3, 0, 2, 1, 1'($urandom));
    // Long stall with frames every other cycle drives the counter into saturation.
    run_pass(2'b01, 2'b00, 0, 0, 600, 600, 2, 1'b0);
    chk("sat_count", 32'(overrun_count), 32'd255);
    run_pass(2'b11, 2'b00, 0, 0, 0, 0, 0, 1'b1);

    // Reset asserted while waiting for done.
    enable_update = 2'b11;
    write_xy      = 2'b00;
    frame_start   = 1'b1;
    tick();
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_valid", 32'(upd_valid), 32'd0);
    chk("async_count", 32'(overrun_count), 32'd0);
    exp_cnt = 0;
    tick();
    reset_n = 1'b1;
    tick();
    run_pass(2'b11, 2'b00, 0, 2, 0, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
